// File: rtl/aes_pkg.sv
// AES key schedule shared definitions: S-box, key-size mode encoding,
// per-mode word/round counts and the GF(2^8) doubling helper.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_AES128  = 2'd0,
    MODE_AES192  = 2'd1,
    MODE_AES256  = 2'd2,
    MODE_ILLEGAL = 2'd3
  } aes_mode_e;

  // Largest schedule (AES-256) in 32-bit words
  localparam int NW_MAX = 60;

  // Indexed by mode: key words, schedule words, rounds
  localparam logic [5:0] NK_LUT [4] = '{6'd4, 6'd6, 6'd8, 6'd0};
  localparam logic [5:0] NW_LUT [4] = '{6'd44, 6'd52, 6'd60, 6'd0};
  localparam logic [3:0] NR_LUT [4] = '{4'd10, 4'd12, 4'd14, 4'd0};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8); 8'h80 wraps to 8'h1b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  genvar gi;
  // One S-box per byte lane
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign word_o[8*gi +: 8] = SBOX[word_i[8*gi +: 8]];
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one schedule word per clock, with a
// registered round-key read port. Optional zeroize feature is enabled by
// defining AES_KEY_SCHEDULE_ZEROIZE_EN (adds zeroize_i and the ZERO state).
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NK_MAX   = 8,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  input  logic                zeroize_i,
`endif
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [255:0]        key_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                keys_valid_o,
  output logic                err_o,
  input  logic [RK_IDX_W-1:0] rk_idx_i,
  output logic [127:0]        rk_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  localparam logic [1:0] ST_ZERO   = 2'd3;
`endif

  localparam logic [5:0] NK_MAX_W = 6'(NK_MAX);
  localparam int         IW       = (RK_IDX_W > 6) ? RK_IDX_W : 6;

  logic [1:0]   state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [255:0] key_q, key_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   phase_q, phase_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         kv_q, kv_d;
  logic [127:0] rk_q, rk_d;

  // Word storage: no reset, contents ignored while keys_valid is low
  logic [31:0] w_mem [NW_MAX];
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;

  logic [5:0]  nk, nk_m1, nw;
  logic [3:0]  nr;
  logic        mode_legal, last_phase, rd_block;
  logic [31:0] prev_word, old_word, sub_in, sub_out, temp_word, new_word;
  logic [31:0] key_words [8];
  logic [31:0] rk_words [4];
  logic [IW-1:0] r_ext, nr_ext;
  logic [5:0]  rk_base;

  assign nk    = NK_LUT[mode_q];
  assign nk_m1 = nk - 6'd1;
  assign nw    = NW_LUT[mode_q];
  assign nr    = NR_LUT[mode_q];

  assign mode_legal = (aes_mode_e'(mode_i) != MODE_ILLEGAL) && (NK_LUT[mode_i] <= NK_MAX_W);
  assign last_phase = ({3'b000, phase_q} == nk_m1);

  genvar gi;
  // Split the latched key into words, w[0] in the top bits
  for (gi = 0; gi < 8; gi++) begin : g_key
    assign key_words[gi] = key_q[255-32*gi -: 32];
  end

  // Recurrence operands for the word being produced this cycle
  assign prev_word = w_mem[idx_q - 6'd1];
  assign old_word  = w_mem[idx_q - nk];
  assign sub_in    = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Select temp per position within the Nk-word period
  always_comb begin
    temp_word = prev_word;
    if (phase_q == 3'd0) begin
      temp_word = sub_out ^ {rcon_q, 24'h0};
    end else if (nk == 6'd8 && phase_q == 3'd4) begin
      temp_word = sub_out;
    end
  end
  assign new_word = old_word ^ temp_word;

  // Next-state, counters and storage write port
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    key_d    = key_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    rcon_d   = rcon_q;
    kv_d     = kv_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rd_block = 1'b0;
    we       = 1'b0;
    waddr    = idx_q;
    wdata    = new_word;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (mode_legal) begin
            state_d  = ST_LOAD;
            mode_d   = mode_i;
            key_d    = key_i;
            idx_d    = 6'd0;
            phase_d  = 3'd0;
            rcon_d   = 8'h01;
            kv_d     = 1'b0;
            rd_block = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        we    = 1'b1;
        wdata = key_words[idx_q[2:0]];
        idx_d = idx_q + 6'd1;
        if (idx_q == nk_m1) begin
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        we      = 1'b1;
        wdata   = new_word;
        idx_d   = idx_q + 6'd1;
        phase_d = last_phase ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (idx_q == nw - 6'd1) begin
          state_d = ST_IDLE;
          idx_d   = 6'd0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
      ST_ZERO: begin
        we    = 1'b1;
        wdata = 32'h0;
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'(NW_MAX - 1)) begin
          state_d = ST_IDLE;
          idx_d   = 6'd0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    // Zeroize overrides everything, including a same-cycle start
    if (zeroize_i) begin
      state_d  = ST_ZERO;
      idx_d    = 6'd0;
      phase_d  = 3'd0;
      rcon_d   = 8'h01;
      kv_d     = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rd_block = 1'b1;
    end
`endif
  end

  // Round-key read: index r covers words 4r..4r+3
  assign r_ext   = IW'(rk_idx_i);
  assign nr_ext  = IW'(nr);
  assign rk_base = {r_ext[3:0], 2'b00};
  for (gi = 0; gi < 4; gi++) begin : g_rk
    assign rk_words[gi] = w_mem[rk_base + 6'(gi)];
  end

  // Out-of-range or not-yet-valid reads return zero
  always_comb begin
    rk_d = 128'h0;
    if (kv_q && !rd_block && (r_ext <= nr_ext)) begin
      rk_d = {rk_words[0], rk_words[1], rk_words[2], rk_words[3]};
    end
  end

  // Storage write, no reset
  always_ff @(posedge clk) begin
    if (we) begin
      w_mem[waddr] <= wdata;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      key_q   <= '0;
      idx_q   <= 6'd0;
      phase_q <= 3'd0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
      rk_q    <= rk_d;
    end
  end

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  assign busy_o = (state_q != ST_IDLE);
`else
  assign busy_o = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
`endif
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign keys_valid_o = kv_q;
  assign rk_o         = rk_q;

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter NK_MAX, default 8, the largest supported key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have parameter RK_IDX_W, default 4, the width of the round-key index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1: request to expand a new key.
REQ-006 SHALL have port mode_i, input, 2: key size, 0=AES-128, 1=AES-192, 2=AES-256, 3=illegal.
REQ-007 SHALL have port key_i, input, 256: cipher key, MSB-first; w[0]=key_i[255:224]; AES-128 uses [255:128] and AES-192 uses [255:64].
REQ-008 SHALL have port busy_o, output, 1: expansion in progress.
REQ-009 SHALL have port done_o, output, 1: one-cycle pulse when the schedule is complete.
REQ-010 SHALL have port keys_valid_o, output, 1: stored schedule is complete and readable.
REQ-011 SHALL have port err_o, output, 1: one-cycle pulse when start_i is rejected.
REQ-012 SHALL have port rk_idx_i, input, RK_IDX_W: round-key index r.
REQ-013 SHALL have port rk_o, output, 128: round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].

Function
REQ-014 SHALL use states IDLE, LOAD and EXPAND; reset enters IDLE.
REQ-015 In IDLE, start_i SHALL latch mode_i and key_i and enter LOAD, with one exception: a mode that is illegal or needs Nk>NK_MAX SHALL pulse err_o the next cycle and stay IDLE.
REQ-016 LOAD SHALL write w[0..Nk-1] to word storage, one word per cycle, over Nk cycles.
REQ-017 EXPAND SHALL produce one word w[i] per cycle from i=Nk up to Nw-1, where Nw=44/52/60 for Nk=4/6/8.
REQ-018 EXPAND SHALL compute w[i] = w[i-Nk] xor temp, with temp=w[i-1], adjusted as follows:
- when i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) xor {rcon,24'h0};
- when Nk=8 and i mod Nk = 4: temp = SubWord(w[i-1]).
REQ-019 i mod Nk SHALL be tracked by a phase counter that wraps at Nk-1; no divider SHALL be used.
REQ-020 rcon SHALL start at 8'h01 and update to xtime(rcon) after each i mod Nk = 0 word; xtime wraps 8'h80 to 8'h1b.
REQ-021 After w[Nw-1] is written, the block SHALL return to IDLE, pulse done_o for one cycle and set keys_valid_o.
- Latency from the start_i cycle to done_o is Nw+1 cycles.
REQ-022 busy_o SHALL be high exactly in LOAD and EXPAND.
REQ-023 An accepted start_i SHALL clear keys_valid_o in the following cycle.
REQ-024 start_i while busy SHALL be ignored, with no err_o pulse.
REQ-025 rk_o SHALL be registered with one-cycle read latency.
- It SHALL be zero when keys_valid_o is low or r>Nr (Nr=10/12/14) in the cycle rk_idx_i is sampled.
REQ-026 A start_i accepted in IDLE while keys_valid_o is high SHALL re-expand; the old schedule becomes unreadable immediately.

Reset
REQ-027 On rst_n low, all of the following SHALL clear asynchronously:
- state to IDLE;
- busy_o, done_o, err_o, keys_valid_o and rk_o to 0;
- counters to 0;
- rcon to 8'h01.
REQ-028 Word storage contents SHALL need no reset; the block SHALL ignore them because keys_valid_o is low.
REQ-029 Reset mid-expansion SHALL abort the expansion; a new start_i SHALL then be required.

Configuration
REQ-030 With macro AES_KEY_SCHEDULE_ZEROIZE_EN defined, the block SHALL have input port zeroize_i, 1 bit, plus state ZERO.
- zeroize_i SHALL be accepted in any state and has priority over start_i.
- ZERO SHALL write zero to all 60 words, one per cycle, holding busy_o high and keys_valid_o low.
- ZERO SHALL then return to IDLE with no done_o pulse.
REQ-031 Without the macro, zeroize_i and ZERO SHALL not exist.

Structure
REQ-032 Package aes_pkg SHALL hold:
- the 256-entry S-box constant;
- the mode enum;
- the NW/NR lookup constants;
- the xtime function.
REQ-033 Sub-module aes_subword, four combinational S-box lookups, SHALL be the only sub-module.

Verification
REQ-034 A bench SHALL cover these scenarios:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c: done_o at cycle 45; rk r=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: done_o at cycle 53; rk r=12 reads e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: rk r=14 reads fe4890d1e6188d0b046df344706c631e.
- mode_i=3, or mode_i=2 with NK_MAX=6: err_o pulses once, busy_o stays 0.
- start_i mid-expansion ignored: result unchanged. Then rst_n low at cycle 20: all outputs 0; rk_idx 0 reads 0.
- With AES_KEY_SCHEDULE_ZEROIZE_EN defined: zeroize_i after AES-128 done: busy_o high for 60 cycles, then rk r=0 reads 0.
